// File: rtl/chiplet_types_pkg.sv
// Shared chiplet link types (flit, node id), the output-port lock state and sizing helpers
// for credit-based ports.
package chiplet_types_pkg;

    localparam int FLIT_W    = 32;
    localparam int NODE_ID_W = 4;

    typedef logic [FLIT_W-1:0]    flit_t;
    typedef logic [NODE_ID_W-1:0] node_id_t;

    typedef enum logic {
        PORT_IDLE,
        PORT_LOCKED
    } port_state_t;

    // A counter must hold every value from 0 up to and including depth.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requests that are also enabled by the mask.
// The search starts just after the last accepted winner.
module rr_arbiter
    import chiplet_types_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant
);

    localparam int IW = index_width(NUM_REQ);

    logic [IW-1:0] last_q;
    logic [IW-1:0] win;
    logic [IW-1:0] sel;
    logic          found;
    int            idx;

    always_comb begin
        grant = '0;
        win   = last_q;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_q) + i) % NUM_REQ;
            sel = IW'(idx);
            if (!found && req[sel] && mask[sel]) begin
                grant[sel] = 1'b1;
                win        = sel;
                found      = 1'b1;
            end
        end
    end

    // Starting with the last request marked as the previous winner gives request 0 top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IW'(NUM_REQ - 1);
        end else if (accept && found) begin
            last_q <= win;
        end
    end

endmodule

// File: rtl/credit_vc_outport.sv
// Credit-based output port multiplexing NUM_VCS virtual channels onto one registered link.
// Optional macro CREDIT_OVERFLOW_CHECK_EN enables the sticky credit_err overflow flag.
module credit_vc_outport
    import chiplet_types_pkg::*;
#(
    parameter int NUM_VCS      = 2,
    parameter int BUFFER_DEPTH = 8,
    parameter int INTERLEAVE   = 0,
    localparam int CW = credit_width(BUFFER_DEPTH),
    localparam int VW = index_width(NUM_VCS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  flit_t [NUM_VCS-1:0]     vc_flit,
    input  logic [NUM_VCS-1:0]      vc_valid,
    input  logic [NUM_VCS-1:0]      vc_last,
    output logic [NUM_VCS-1:0]      vc_ready,
    input  logic [NUM_VCS-1:0]      credit_granted,
    output flit_t                   out,
    output logic [VW-1:0]           out_vc,
    output logic                    data_ready_out,
    output logic                    packet_sent,
    output logic [NUM_VCS*CW-1:0]   credit_count,
    output logic                    credit_err
);

    logic [CW-1:0]      credit [NUM_VCS];
    logic [NUM_VCS-1:0] eligible;
    logic [NUM_VCS-1:0] lock_mask;
    logic [NUM_VCS-1:0] grant;
    logic [VW-1:0]      grant_vc;
    logic [VW-1:0]      lock_vc;
    logic               any_grant;
    port_state_t        state;

    // While a wormhole packet is in flight only its VC may be granted, even if it is out of credit.
    always_comb begin
        eligible  = '0;
        lock_mask = '1;
        grant_vc  = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            eligible[v] = vc_valid[v] && (credit[v] != '0);
            if (grant[v]) begin
                grant_vc = VW'(v);
            end
        end
        if (INTERLEAVE == 0 && state == PORT_LOCKED) begin
            lock_mask          = '0;
            lock_mask[lock_vc] = 1'b1;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_VCS)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (eligible),
        .mask   (lock_mask),
        .accept (any_grant),
        .grant  (grant)
    );

    assign vc_ready  = grant;
    assign any_grant = |grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= PORT_IDLE;
            lock_vc        <= '0;
            out            <= '0;
            out_vc         <= '0;
            data_ready_out <= 1'b0;
            packet_sent    <= 1'b0;
        end else begin
            data_ready_out <= any_grant;
            packet_sent    <= any_grant && vc_last[grant_vc];
            if (any_grant) begin
                out    <= vc_flit[grant_vc];
                out_vc <= grant_vc;
            end
            if (INTERLEAVE == 0 && any_grant) begin
                case (state)
                    PORT_IDLE: begin
                        if (!vc_last[grant_vc]) begin
                            state   <= PORT_LOCKED;
                            lock_vc <= grant_vc;
                        end
                    end
                    PORT_LOCKED: begin
                        if (vc_last[grant_vc]) begin
                            state <= PORT_IDLE;
                        end
                    end
                    default: state <= PORT_IDLE;
                endcase
            end
        end
    end

    // A returned credit that would exceed the downstream buffer size is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                credit[v] <= CW'(BUFFER_DEPTH);
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (grant[v] && !credit_granted[v]) begin
                    credit[v] <= credit[v] - CW'(1);
                end else if (credit_granted[v] && !grant[v] && credit[v] != CW'(BUFFER_DEPTH)) begin
                    credit[v] <= credit[v] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        credit_count = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            credit_count[v*CW +: CW] = credit[v];
        end
    end

`ifdef CREDIT_OVERFLOW_CHECK_EN
    logic overflow_attempt;

    always_comb begin
        overflow_attempt = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (credit_granted[v] && !grant[v] && credit[v] == CW'(BUFFER_DEPTH)) begin
                overflow_attempt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_err <= 1'b0;
        end else if (overflow_attempt) begin
            credit_err <= 1'b1;
        end
    end
`else
    assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_credit_vc_outport.sv
// Scoreboard bench for credit_vc_outport: a wormhole instance and an interleaving instance,
// expected flits queued at issue time and checked by per-instance output monitors.
module tb_credit_vc_outport;
    import chiplet_types_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    flit_t [1:0] vc_flit;
    logic [1:0]  vc_valid, vc_last, vc_ready, credit_granted;
    flit_t       out;
    logic        out_vc, data_ready_out, packet_sent, credit_err;
    logic [7:0]  credit_count;

    flit_t [1:0] il_flit;
    logic [1:0]  il_valid, il_last, il_ready, il_credit_granted;
    flit_t       il_out;
    logic        il_out_vc, il_data_ready_out, il_packet_sent, il_credit_err;
    logic [7:0]  il_credit_count;

`ifdef CREDIT_OVERFLOW_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    typedef struct {
        flit_t flit;
        logic  vc;
        logic  last;
        int    cyc;
    } exp_t;

    exp_t mainQ[$];
    exp_t ilQ[$];
    exp_t eMain, eIl;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    credit_vc_outport #(.NUM_VCS(2), .BUFFER_DEPTH(8), .INTERLEAVE(0)) dut (
        .clk(clk), .rst(rst), .vc_flit(vc_flit), .vc_valid(vc_valid), .vc_last(vc_last),
        .vc_ready(vc_ready), .credit_granted(credit_granted), .out(out), .out_vc(out_vc),
        .data_ready_out(data_ready_out), .packet_sent(packet_sent),
        .credit_count(credit_count), .credit_err(credit_err)
    );

    credit_vc_outport #(.NUM_VCS(2), .BUFFER_DEPTH(8), .INTERLEAVE(1)) dut_il (
        .clk(clk), .rst(rst), .vc_flit(il_flit), .vc_valid(il_valid), .vc_last(il_last),
        .vc_ready(il_ready), .credit_granted(il_credit_granted), .out(il_out), .out_vc(il_out_vc),
        .data_ready_out(il_data_ready_out), .packet_sent(il_packet_sent),
        .credit_count(il_credit_count), .credit_err(il_credit_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got a flit expected none", name);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (data_ready_out) begin
                if (mainQ.size() == 0) begin
                    failNow("main unexpected flit");
                end else begin
                    eMain = mainQ.pop_front();
                    checkOutput("main out", out, eMain.flit);
                    checkOutput("main out_vc", out_vc, eMain.vc);
                    checkOutput("main packet_sent", packet_sent, eMain.last);
                    checkOutput("main latency", cyc, eMain.cyc);
                end
            end else begin
                checkOutput("main packet_sent idle", packet_sent, 0);
                if (mainQ.size() > 0 && mainQ[0].cyc <= cyc) begin
                    checkOutput("main missing flit", data_ready_out, 1);
                    mainQ.delete(0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (il_data_ready_out) begin
                if (ilQ.size() == 0) begin
                    failNow("il unexpected flit");
                end else begin
                    eIl = ilQ.pop_front();
                    checkOutput("il out", il_out, eIl.flit);
                    checkOutput("il out_vc", il_out_vc, eIl.vc);
                    checkOutput("il packet_sent", il_packet_sent, eIl.last);
                    checkOutput("il latency", cyc, eIl.cyc);
                end
            end else if (ilQ.size() > 0 && ilQ[0].cyc <= cyc) begin
                checkOutput("il missing flit", il_data_ready_out, 1);
                ilQ.delete(0);
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] last, input flit_t f0,
                                 input flit_t f1, input logic [1:0] cg, input logic [1:0] expReady);
        @(posedge clk);
        #1;
        vc_valid       = valid;
        vc_last        = last;
        vc_flit[0]     = f0;
        vc_flit[1]     = f1;
        credit_granted = cg;
        #2;
        checkOutput("main vc_ready", vc_ready, expReady);
        if (expReady[0]) mainQ.push_back('{f0, 1'b0, last[0], cyc + 1});
        if (expReady[1]) mainQ.push_back('{f1, 1'b1, last[1], cyc + 1});
    endtask

    task automatic applyIl(input logic [1:0] valid, input logic [1:0] last, input flit_t f0,
                           input flit_t f1, input logic [1:0] expReady);
        @(posedge clk);
        #1;
        il_valid   = valid;
        il_last    = last;
        il_flit[0] = f0;
        il_flit[1] = f1;
        #2;
        checkOutput("il vc_ready", il_ready, expReady);
        if (expReady[0]) ilQ.push_back('{f0, 1'b0, last[0], cyc + 1});
        if (expReady[1]) ilQ.push_back('{f1, 1'b1, last[1], cyc + 1});
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mainQ.delete();
        ilQ.delete();
        vc_valid = '0; vc_last = '0; vc_flit = '0; credit_granted = '0;
        il_valid = '0; il_last = '0; il_flit = '0; il_credit_granted = '0;
        #2;
        checkOutput("reset credit_count", credit_count, 8'h88);
        checkOutput("reset data_ready_out", data_ready_out, 0);
        checkOutput("reset packet_sent", packet_sent, 0);
        checkOutput("reset credit_err", credit_err, 0);
        checkOutput("reset out", out, 0);
        checkOutput("reset out_vc", out_vc, 0);
        checkOutput("reset il credit_count", il_credit_count, 8'h88);
        checkOutput("reset il data_ready_out", il_data_ready_out, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vc_valid = '0; vc_last = '0; vc_flit = '0; credit_granted = '0;
        il_valid = '0; il_last = '0; il_flit = '0; il_credit_granted = '0;
        doReset();

        // VC0 drains all eight credits, then the ninth flit waits for a returned credit.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(2'b01, 2'b01, flit_t'(32'h100 + k), '0, 2'b00, 2'b01);
        end
        applyStimulus(2'b01, 2'b01, 32'h108, '0, 2'b01, 2'b00);
        checkOutput("credits drained", credit_count, 8'h80);
        applyStimulus(2'b01, 2'b01, 32'h108, '0, 2'b00, 2'b01);
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b00, 2'b00);
        checkOutput("credits after ninth", credit_count, 8'h80);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(2'b00, 2'b00, '0, '0, 2'b01, 2'b00);
        end
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b01, 2'b00);
        checkOutput("credits refilled", credit_count, 8'h88);
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b00, 2'b00);
        checkOutput("vc0 saturate", credit_count, 8'h88);
        checkOutput("vc0 overflow credit_err", credit_err, ERR_EXP);

        // Wormhole: the VC0 packet stays contiguous, VC1 follows its tail.
        doReset();
        applyStimulus(2'b11, 2'b10, 32'hA0, 32'hB0, 2'b00, 2'b01);
        applyStimulus(2'b11, 2'b10, 32'hA1, 32'hB0, 2'b00, 2'b01);
        applyStimulus(2'b11, 2'b11, 32'hA2, 32'hB0, 2'b00, 2'b01);
        applyStimulus(2'b10, 2'b10, '0, 32'hB0, 2'b00, 2'b10);

        // Grant and credit return together on VC1 at credit 5, then saturation at 8.
        applyStimulus(2'b10, 2'b10, '0, 32'hB1, 2'b00, 2'b10);
        applyStimulus(2'b10, 2'b10, '0, 32'hB2, 2'b00, 2'b10);
        applyStimulus(2'b10, 2'b10, '0, 32'hB3, 2'b10, 2'b10);
        checkOutput("vc1 at five", credit_count, 8'h55);
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b00, 2'b00);
        checkOutput("grant plus return", credit_count, 8'h55);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b00, 2'b00, '0, '0, 2'b11, 2'b00);
        end
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b10, 2'b00);
        checkOutput("credits back to eight", credit_count, 8'h88);
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b00, 2'b00);
        checkOutput("vc1 saturate", credit_count, 8'h88);
        checkOutput("vc1 overflow credit_err", credit_err, ERR_EXP);

        // Reset while locked on VC1: lock and in-flight flit are dropped, VC0 wins afterwards.
        applyStimulus(2'b10, 2'b00, '0, 32'hC0, 2'b00, 2'b10);
        applyStimulus(2'b11, 2'b00, 32'hD0, 32'hC1, 2'b00, 2'b10);
        doReset();
        applyStimulus(2'b11, 2'b11, 32'hE0, 32'hE1, 2'b00, 2'b01);
        applyStimulus(2'b10, 2'b10, '0, 32'hE1, 2'b00, 2'b10);
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b00, 2'b00);

        // Per-flit interleaving alternates VCs even inside multi-flit packets.
        for (int k = 0; k < 4; k++) begin
            applyIl(2'b11, 2'b00, flit_t'(32'hF0 + k), flit_t'(32'hF8 + k), (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        applyIl(2'b00, 2'b00, '0, '0, 2'b00);
        checkOutput("il credits", il_credit_count, 8'h66);
        checkOutput("main credits", credit_count, 8'h77);

        applyStimulus(2'b00, 2'b00, '0, '0, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b00, 2'b00);
        checkOutput("main queue drained", mainQ.size(), 0);
        checkOutput("il queue drained", ilQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
